mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle control unit that sequences the RV32I datapath one instruction at a time. It decodes `instrCode`, drives every datapath control input plus a new PC-register enable, and runs a req/ready handshake with data memory so loads and stores tolerate wait states. It sits beside `DataPath` in the CPU top, replacing the single-cycle combinational decoder.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `instrCode`  in  32  current instruction; held stable while `pcEn`=0
- `pcEn`  out  1  PC register load enable; the datapath PC updates only when this is 1
- `regFileWe`  out  1  register-file write enable
- `aluControl`  out  4  ALU operation / branch condition
- `aluSrcMuxSel`  out  1  ALU B operand: 0 = rs2, 1 = immExt
- `RFWDSrcMuxSel`  out  3  write-back select: 0 = ALU, 1 = dataRData, 2 = immExt, 3 = PC+imm, 4 = PC+4
- `branch`  out  1  conditional-branch qualifier
- `jal`  out  1  unconditional PC+imm redirect
- `jalr`  out  1  adder base = rs1
- `dataReq`  out  1  data-memory request
- `dataWe`  out  1  data-memory write; valid only with `dataReq`
- `dataReady`  in  1  data memory has accepted the write or returned read data
- `instrDone`  out  1  one-cycle pulse when an instruction retires
- `illegalInstr`  out  1  sticky illegal-opcode flag

## Operation
- FSM states:
  - **FETCH → DECODE**: unconditional.
  - **DECODE**: R, I, B, LU, AU, J and JL go to EXE; L and S go to MEM_ADDR; any other opcode goes to HALT.
  - **EXE → FETCH**:
    - `pcEn`=1 and `instrDone`=1.
    - `regFileWe`=1 for all opcodes except B.
  - **MEM_ADDR → MEM_W** for S, **→ MEM_R** for L.
  - **MEM_W**:
    - `dataReq`=`dataWe`=1, held until `dataReady`.
    - On the `dataReady` cycle: `pcEn`=1, `instrDone`=1, then FETCH.
  - **MEM_R**: `dataReq`=1, `dataWe`=0, held until `dataReady`, then WB.
  - **WB**: `regFileWe`=1, `RFWDSrcMuxSel`=1, `pcEn`=1, `instrDone`=1, then FETCH.
  - **HALT**: `illegalInstr`=1; `pcEn`, `regFileWe` and `dataReq` are 0; exits only on reset.
- Decode is combinational from `instrCode` in every state. `regFileWe`, `pcEn`, `dataReq`, `dataWe` and `instrDone` are gated by state as listed above.
- `aluControl` per opcode:
  - R: {f7[5], f3}.
  - I: {f7[5] if f3=101 else 0, f3}.
  - B: {0, f3}.
  - L, S, LU, AU, J, JL: ADD.
- `aluSrcMuxSel`: 1 for I, L and S; 0 otherwise.
- `RFWDSrcMuxSel`: R/I = 0, L = 1, LU = 2, AU = 3, J/JL = 4.
- `branch`=1 for B. `jal`=1 for both J and JL. `jalr`=1 for JL only.
- `dataReady` outside MEM_W/MEM_R is ignored.
- Reset mid-operation: an in-flight `dataReq` drops immediately. No write-enable may be asserted in the reset cycle.

## Timing
- Reset values:
  - State = FETCH, `illegalInstr`=0.
  - Every output is 0: `pcEn`, `regFileWe`, `dataReq`, `dataWe`, `branch`, `jal`, `jalr`, `instrDone`.
- Cycles per instruction (N = number of cycles `dataReady` stays low while `dataReq` is high):
  - R, I, B, LU, AU, J, JL: 3 (FETCH, DECODE, EXE).
  - Store: 4+N.
  - Load: 5+N.
- Handshake:
  - `dataReq` rises on entry to MEM_W/MEM_R.
  - Address and write data stay stable while `dataReq` is high.
  - The transfer completes on the clock edge where `dataReq` and `dataReady` are both 1.
  - `dataReq` deasserts the following cycle.
- `pcEn` is high for exactly one cycle per retired instruction, coincident with `instrDone`.

## Structure
- Shared package `rv32i_pkg`:
  - Opcodes: R 0110011, L 0000011, I 0010011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
  - ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Write-back select codes and the FSM state enum.
- One sub-module `instr_decoder`: combinational mapping `instrCode` → {`aluControl`, `aluSrcMuxSel`, `RFWDSrcMuxSel`, `branch`, `jal`, `jalr`, class}.
- `DataPath` gains a `pcEn` input on its PC register.

## Test plan
- `instrCode`=0x002081B3 (ADD x3,x1,x2) → EXE after 2 cycles; `aluControl`=0000, `RFWDSrcMuxSel`=0, `regFileWe`=`pcEn`=1 for 1 cycle; retires in 3 cycles.
- 0x402081B3 (SUB), then 0x4030D093 (SRAI x1,x1,3) → `aluControl`=1000, then 1101 with `aluSrcMuxSel`=1.
- 0x0040A283 (LW x5,4(x1)) with `dataReady` held low 2 cycles → `dataReq` high 3 cycles, `dataWe`=0; WB asserts `regFileWe`, `RFWDSrcMuxSel`=1; 7 cycles total.
- 0x0020A423 (SW x2,8(x1)) with `dataReady` immediate → `dataReq`=`dataWe`=1 for 1 cycle, `regFileWe` never 1; 4 cycles total.
- 0x00208463 (BEQ) → `branch`=1, `aluControl`=0000, `regFileWe`=0; `jal`/`jalr` checked on 0x0000006F and 0x000080E7.
- 0x0000007F → HALT: `illegalInstr`=1, `pcEn` stays 0; reset asserted mid-MEM_R drops `dataReq` asynchronously and returns to FETCH.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU and write-back select codes, and the
// control-unit state and instruction-class enums.
package rv32i_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_MEM   = 3'd1;
  localparam logic [2:0] WB_IMM   = 3'd2;
  localparam logic [2:0] WB_PCIMM = 3'd3;
  localparam logic [2:0] WB_PC4   = 3'd4;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXE,
    ST_MEM_ADDR,
    ST_MEM_W,
    ST_MEM_R,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_L,
    CLS_S,
    CLS_B,
    CLS_LU,
    CLS_AU,
    CLS_J,
    CLS_JL,
    CLS_ILL
  } instr_class_e;

endpackage

// File: rtl/mc_control_unit_if.sv
// Data-memory request/ready handshake between the control unit and memory.
interface mc_control_unit_if;
  logic dataReq;
  logic dataWe;
  logic dataReady;

  modport master (output dataReq, output dataWe, input dataReady);
  modport slave  (input dataReq, input dataWe, output dataReady);
endinterface

// File: rtl/mc_control_unit_instr_decoder.sv
// Combinational RV32I decode: opcode/funct fields to datapath select signals
// and an instruction class used by the sequencing FSM.
module instr_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0]  instrCode_i,
  output logic [3:0]   aluControl_o,
  output logic         aluSrcMuxSel_o,
  output logic [2:0]   RFWDSrcMuxSel_o,
  output logic         branch_o,
  output logic         jal_o,
  output logic         jalr_o,
  output instr_class_e cls_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instrCode_i[6:0];
  assign f3          = instrCode_i[14:12];
  assign f7b5        = instrCode_i[30];
  assign unused_bits = ^{instrCode_i[31], instrCode_i[29:15], instrCode_i[11:7]};

  always_comb begin
    aluControl_o    = ALU_ADD;
    aluSrcMuxSel_o  = 1'b0;
    RFWDSrcMuxSel_o = WB_ALU;
    branch_o        = 1'b0;
    jal_o           = 1'b0;
    jalr_o          = 1'b0;
    cls_o           = CLS_ILL;
    unique case (opcode)
      OP_R: begin
        cls_o        = CLS_R;
        aluControl_o = {f7b5, f3};
      end
      OP_I: begin
        cls_o          = CLS_I;
        // Only the shift-right immediates carry the arithmetic/logical bit in f7.
        aluControl_o   = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
        aluSrcMuxSel_o = 1'b1;
      end
      OP_B: begin
        cls_o        = CLS_B;
        aluControl_o = {1'b0, f3};
        branch_o     = 1'b1;
      end
      OP_L: begin
        cls_o           = CLS_L;
        aluSrcMuxSel_o  = 1'b1;
        RFWDSrcMuxSel_o = WB_MEM;
      end
      OP_S: begin
        cls_o          = CLS_S;
        aluSrcMuxSel_o = 1'b1;
      end
      OP_LU: begin
        cls_o           = CLS_LU;
        RFWDSrcMuxSel_o = WB_IMM;
      end
      OP_AU: begin
        cls_o           = CLS_AU;
        RFWDSrcMuxSel_o = WB_PCIMM;
      end
      OP_J: begin
        cls_o           = CLS_J;
        RFWDSrcMuxSel_o = WB_PC4;
        jal_o           = 1'b1;
      end
      OP_JL: begin
        cls_o           = CLS_JL;
        RFWDSrcMuxSel_o = WB_PC4;
        jal_o           = 1'b1;
        jalr_o          = 1'b1;
      end
      default: cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXE and the
// load/store memory handshake, gating write and PC enables by state.
module mc_control_unit
  import rv32i_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instrCode,
  output logic                      pcEn,
  output logic                      regFileWe,
  output logic [3:0]                aluControl,
  output logic                      aluSrcMuxSel,
  output logic [2:0]                RFWDSrcMuxSel,
  output logic                      branch,
  output logic                      jal,
  output logic                      jalr,
  output logic                      instrDone,
  output logic                      illegalInstr,
  mc_control_unit_if.master         dmem
);

  state_e       state_q, state_d;
  instr_class_e cls;
  logic         branch_dec, jal_dec, jalr_dec;
  logic         pcEn_q, regFileWe_q, dataReq_q, dataWe_q, illegal_q;
  logic         storeDone;

  instr_decoder u_dec (
    .instrCode_i     (instrCode),
    .aluControl_o    (aluControl),
    .aluSrcMuxSel_o  (aluSrcMuxSel),
    .RFWDSrcMuxSel_o (RFWDSrcMuxSel),
    .branch_o        (branch_dec),
    .jal_o           (jal_dec),
    .jalr_o          (jalr_dec),
    .cls_o           (cls)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (cls)
          CLS_R, CLS_I, CLS_B, CLS_LU, CLS_AU, CLS_J, CLS_JL: state_d = ST_EXE;
          CLS_L, CLS_S:                                       state_d = ST_MEM_ADDR;
          default:                                            state_d = ST_HALT;
        endcase
      end
      ST_EXE:      state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (cls == CLS_S) ? ST_MEM_W : ST_MEM_R;
      ST_MEM_W:    state_d = dmem.dataReady ? ST_FETCH : ST_MEM_W;
      ST_MEM_R:    state_d = dmem.dataReady ? ST_WB : ST_MEM_R;
      ST_WB:       state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Enables are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pcEn_q      <= 1'b0;
      regFileWe_q <= 1'b0;
      dataReq_q   <= 1'b0;
      dataWe_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcEn_q      <= (state_d == ST_EXE) || (state_d == ST_WB);
      regFileWe_q <= ((state_d == ST_EXE) && (cls != CLS_B)) || (state_d == ST_WB);
      dataReq_q   <= (state_d == ST_MEM_W) || (state_d == ST_MEM_R);
      dataWe_q    <= (state_d == ST_MEM_W);
      illegal_q   <= illegal_q || (state_d == ST_HALT);
    end
  end

  // A store retires in the same cycle memory accepts it, so this term cannot be registered.
  assign storeDone    = (state_q == ST_MEM_W) && dmem.dataReady;
  assign pcEn         = pcEn_q || storeDone;
  assign instrDone    = pcEn;
  assign regFileWe    = regFileWe_q;
  assign dmem.dataReq = dataReq_q;
  assign dmem.dataWe  = dataWe_q;
  assign illegalInstr = illegal_q;
  assign branch       = branch_dec && !reset;
  assign jal          = jal_dec && !reset;
  assign jalr         = jalr_dec && !reset;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-instruction cycle counts, decode
// fields, memory handshake with wait states, HALT and async reset.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        pcEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, instrDone, illegalInstr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;

  mc_control_unit_if dmem ();

  mc_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .pcEn          (pcEn),
    .regFileWe     (regFileWe),
    .aluControl    (aluControl),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .instrDone     (instrDone),
    .illegalInstr  (illegalInstr),
    .dmem          (dmem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         r_cyc, r_req, r_we, r_rfwe, r_pcen;
  logic       r_done, r_idone, r_src, r_br, r_jal, r_jalr;
  logic [3:0] r_alu;
  logic [2:0] r_rfwd, r_rfwd_we;

  // Called one step after a clock edge with the FSM in FETCH. Memory answers
  // once dataReq has been seen for more than wait_n cycles.
  task automatic run_instr(input logic [31:0] code, input int wait_n,
                           input bit ready_always, input int budget);
    instrCode = code;
    r_cyc = 0; r_req = 0; r_we = 0; r_rfwe = 0; r_pcen = 0;
    r_done = 0; r_idone = 0; r_rfwd_we = 3'd7;
    for (int c = 0; c < budget; c++) begin
      r_cyc++;
      if (dmem.dataReq) begin
        r_req++;
        if (dmem.dataWe) r_we++;
      end
      dmem.dataReady = ready_always || (dmem.dataReq && (r_req > wait_n));
      #1;
      r_alu = aluControl; r_src = aluSrcMuxSel; r_rfwd = RFWDSrcMuxSel;
      r_br = branch; r_jal = jal; r_jalr = jalr;
      if (regFileWe) begin
        r_rfwe++;
        r_rfwd_we = RFWDSrcMuxSel;
      end
      if (pcEn) begin
        r_pcen++;
        r_done  = 1'b1;
        r_idone = instrDone;
      end
      @(posedge clk); #1;
      dmem.dataReady = 1'b0;
      if (r_done) break;
    end
  endtask

  initial begin
    reset = 1'b1;
    instrCode = 32'h000080E7;
    dmem.dataReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcEn", pcEn, 0);
    chk("rst_regFileWe", regFileWe, 0);
    chk("rst_dataReq", dmem.dataReq, 0);
    chk("rst_dataWe", dmem.dataWe, 0);
    chk("rst_branch", branch, 0);
    chk("rst_jal", jal, 0);
    chk("rst_jalr", jalr, 0);
    chk("rst_instrDone", instrDone, 0);
    chk("rst_illegal", illegalInstr, 0);
    reset = 1'b0;

    run_instr(32'h002081B3, 0, 0, 10);
    chk("add_done", r_done, 1);
    chk("add_cycles", r_cyc, 3);
    chk("add_alu", r_alu, 4'b0000);
    chk("add_rfwd", r_rfwd_we, 0);
    chk("add_rfwe", r_rfwe, 1);
    chk("add_idone", r_idone, 1);
    chk("add_req", r_req, 0);
    #1 chk("add_pcEn_after", pcEn, 0);

    run_instr(32'h402081B3, 0, 0, 10);
    chk("sub_cycles", r_cyc, 3);
    chk("sub_alu", r_alu, 4'b1000);
    chk("sub_src", r_src, 0);

    run_instr(32'h4030D093, 0, 0, 10);
    chk("srai_cycles", r_cyc, 3);
    chk("srai_alu", r_alu, 4'b1101);
    chk("srai_src", r_src, 1);

    run_instr(32'h0040A283, 2, 0, 20);
    chk("lw_done", r_done, 1);
    chk("lw_cycles", r_cyc, 7);
    chk("lw_req", r_req, 3);
    chk("lw_we", r_we, 0);
    chk("lw_rfwe", r_rfwe, 1);
    chk("lw_rfwd", r_rfwd_we, 1);
    chk("lw_pcen", r_pcen, 1);
    #1 chk("lw_req_after", dmem.dataReq, 0);

    run_instr(32'h0020A423, 0, 0, 20);
    chk("sw_done", r_done, 1);
    chk("sw_cycles", r_cyc, 4);
    chk("sw_req", r_req, 1);
    chk("sw_we", r_we, 1);
    chk("sw_rfwe", r_rfwe, 0);
    chk("sw_src", r_src, 1);
    #1 chk("sw_req_after", dmem.dataReq, 0);

    run_instr(32'h0020A423, 3, 0, 20);
    chk("sw3_cycles", r_cyc, 7);
    chk("sw3_req", r_req, 4);

    run_instr(32'h0020A423, 0, 1, 20);
    chk("sw_rdy_early_cycles", r_cyc, 4);
    chk("sw_rdy_early_pcen", r_pcen, 1);

    run_instr(32'h00208463, 0, 0, 10);
    chk("beq_cycles", r_cyc, 3);
    chk("beq_branch", r_br, 1);
    chk("beq_alu", r_alu, 4'b0000);
    chk("beq_rfwe", r_rfwe, 0);
    chk("beq_jal", r_jal, 0);

    run_instr(32'h0000006F, 0, 0, 10);
    chk("jal_cycles", r_cyc, 3);
    chk("jal_jal", r_jal, 1);
    chk("jal_jalr", r_jalr, 0);
    chk("jal_rfwd", r_rfwd_we, 4);
    chk("jal_rfwe", r_rfwe, 1);

    run_instr(32'h000080E7, 0, 0, 10);
    chk("jalr_jal", r_jal, 1);
    chk("jalr_jalr", r_jalr, 1);
    chk("jalr_branch", r_br, 0);

    run_instr(32'h000012B7, 0, 0, 10);
    chk("lui_rfwd", r_rfwd_we, 2);
    run_instr(32'h00001297, 0, 0, 10);
    chk("auipc_rfwd", r_rfwd_we, 3);

    run_instr(32'h0000007F, 0, 0, 6);
    chk("halt_no_retire", r_done, 0);
    chk("halt_rfwe", r_rfwe, 0);
    chk("halt_req", r_req, 0);
    chk("halt_illegal", illegalInstr, 1);
    chk("halt_pcEn", pcEn, 0);

    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2_illegal", illegalInstr, 0);
    reset = 1'b0;
    instrCode = 32'h0040A283;
    repeat (3) @(posedge clk);
    #1;
    chk("memr_req", dmem.dataReq, 1);
    chk("memr_we", dmem.dataWe, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_req_drop", dmem.dataReq, 0);
    chk("async_pcEn", pcEn, 0);
    chk("async_rfwe", regFileWe, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(32'h002081B3, 0, 0, 10);
    chk("post_rst_cycles", r_cyc, 3);
    chk("post_rst_done", r_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
